// File: rtl/weight_pkg.sv
// +----------------------------------------------------------------+
// | weight_pkg: shared types and sizing for the weight read path     |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
`default_nettype none

package weight_pkg;

  localparam int WP_NUM_REQ     = 4;
  localparam int WP_FV_SIZE     = 16;
  localparam int WP_MULT_PER_PE = 4;
  localparam int WP_MAX_FV_NUM  = 16;
  localparam int WP_MAX_LAYERS  = 2;
  localparam int WP_RD_LATENCY  = 1;

  localparam int BPL = WP_MAX_FV_NUM / WP_MULT_PER_PE;
  localparam int AW  = $clog2(WP_MAX_LAYERS * BPL);
  localparam int LW  = $clog2(WP_MAX_LAYERS);
  localparam int IW  = (WP_NUM_REQ > 1) ? $clog2(WP_NUM_REQ) : 1;
  localparam int NW  = $clog2(WP_MAX_FV_NUM) + 1;
  // Beat counter width: must hold the full count BPL, not just BPL-1
  localparam int CW  = $clog2(BPL + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] id;
    logic [NW-1:0] fv_base;
    logic          sos;
    logic          eos;
  } weight_beat_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------+
// | rr_arbiter: one-hot round-robin pick, searching upward from ptr  |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  logic [IW-1:0] idx;

  // Scan from the farthest candidate down so the last hit is the one nearest ptr
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/weight_read_arbiter.sv
// +----------------------------------------------------------------+
// | weight_read_arbiter: round-robin share of the weight SRAM port   |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
`default_nettype none

module weight_read_arbiter
  import weight_pkg::*;
#(
  parameter int NUM_REQ     = WP_NUM_REQ,
  parameter int FV_SIZE     = WP_FV_SIZE,
  parameter int MULT_PER_PE = WP_MULT_PER_PE,
  parameter int MAX_LAYERS  = WP_MAX_LAYERS,
  parameter int RD_LATENCY  = WP_RD_LATENCY
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][LW:0]        req_layer,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NW-1:0]                   num_fv,
  output logic                            mem_rd_en,
  output logic [AW-1:0]                   mem_rd_addr,
  input  logic [MULT_PER_PE*FV_SIZE-1:0]  mem_rd_data,
  output logic                            out_valid,
  output logic [IW-1:0]                   out_id,
  output logic [MULT_PER_PE*FV_SIZE-1:0]  out_data,
  output logic [NW-1:0]                   out_fv_base,
  output logic                            out_sos,
  output logic                            out_eos,
  output logic                            err_layer,
  output logic                            busy
);

  state_t        state, state_nxt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] cur_id;
  logic [LW-1:0] cur_layer;
  logic [CW-1:0] beats;
  logic [CW-1:0] beat;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  logic          grant_fire;
  logic [LW:0]   grant_layer;
  logic          layer_bad;
  logic [CW-1:0] grant_beats;
  logic          last_beat;

  weight_beat_t issue_beat;
  weight_beat_t pipe [RD_LATENCY];

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  assign grant_fire  = (state == ST_IDLE) && arb_any && !reset;
  assign grant_layer = req_layer[arb_idx];
  assign layer_bad   = (grant_layer >= (LW+1)'(MAX_LAYERS));
  assign grant_beats = CW'(num_fv / MULT_PER_PE);
  assign last_beat   = (beat == beats - CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Rejected layers and empty layers complete the handshake without leaving IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_fire && !layer_bad && (grant_beats != '0)) begin
          state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (last_beat) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    if (grant_fire) begin
      req_ready = arb_grant;
    end
    if (state == ST_BURST) begin
      mem_rd_en   = 1'b1;
      mem_rd_addr = AW'(cur_layer * BPL) + AW'(beat);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      cur_id    <= '0;
      cur_layer <= '0;
      beats     <= '0;
      beat      <= '0;
      err_layer <= 1'b0;
    end else begin
      err_layer <= 1'b0;
      if (grant_fire) begin
        rr_ptr    <= (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
        cur_id    <= arb_idx;
        cur_layer <= grant_layer[LW-1:0];
        beats     <= grant_beats;
        beat      <= '0;
        err_layer <= layer_bad;
      end else if (state == ST_BURST) begin
        beat <= beat + CW'(1);
      end
    end
  end

  always_comb begin
    issue_beat = '0;
    if (state == ST_BURST) begin
      issue_beat.valid   = 1'b1;
      issue_beat.id      = cur_id;
      issue_beat.fv_base = NW'(beat * MULT_PER_PE);
      issue_beat.sos     = (beat == '0);
      issue_beat.eos     = last_beat;
    end
  end

  // Sideband travels with the read so it lines up with mem_rd_data
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= issue_beat;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign out_valid   = pipe[RD_LATENCY-1].valid;
  assign out_id      = pipe[RD_LATENCY-1].id;
  assign out_fv_base = pipe[RD_LATENCY-1].fv_base;
  assign out_sos     = pipe[RD_LATENCY-1].sos;
  assign out_eos     = pipe[RD_LATENCY-1].eos;
  assign out_data    = pipe[RD_LATENCY-1].valid ? mem_rd_data : '0;

  always_comb begin
    busy = (state == ST_BURST);
    for (int i = 0; i < RD_LATENCY; i++) begin
      busy = busy | pipe[i].valid;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_weight_read_arbiter.sv
// +----------------------------------------------------------------+
// | tb_weight_read_arbiter: directed + random bench with a cycle model |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
`default_nettype none

module tb_weight_read_arbiter;

  localparam int NREQ = 4;
  localparam int MPE  = 4;
  localparam int MAXL = 2;
  localparam int LAT  = 1;
  localparam int BPLT = 4;
  localparam int RING = 64;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0][1:0] req_layer = '0;
  logic [NREQ-1:0]      req_ready;
  logic [4:0]           num_fv = '0;
  logic                 mem_rd_en;
  logic [2:0]           mem_rd_addr;
  logic [63:0]          mem_rd_data;
  logic                 out_valid;
  logic [1:0]           out_id;
  logic [63:0]          out_data;
  logic [4:0]           out_fv_base;
  logic                 out_sos, out_eos, err_layer, busy;

  weight_read_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_layer(req_layer),
    .req_ready(req_ready), .num_fv(num_fv), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .out_valid(out_valid),
    .out_id(out_id), .out_data(out_data), .out_fv_base(out_fv_base),
    .out_sos(out_sos), .out_eos(out_eos), .err_layer(err_layer), .busy(busy)
  );

  always #5 clk = ~clk;

  // SRAM with one-cycle read latency
  logic [63:0] mem [MAXL*BPLT];
  logic [63:0] sram_q = '0;
  always @(posedge clk) sram_q <= (mem_rd_en === 1'b1) ? mem[mem_rd_addr] : 64'h0;
  assign mem_rd_data = sram_q;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: per-cycle expectation ring, filled at each predicted grant
  int  cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          chk_en = 1'b0;
  bit          rd_v [RING];
  int          rd_a [RING];
  bit          ov   [RING];
  int          oid  [RING];
  int          obase[RING];
  bit          osos [RING];
  bit          oeos [RING];
  logic [63:0] odat [RING];
  bit          ev   [RING];
  bit          bv   [RING];
  int          m_ptr = 0;
  int          busy_end = -1;
  int          rd_count = 0, err_count = 0, last_rd = 0;
  int          glog[$];
  int          gcyc[$];

  int s, win, lay, nb, t1, t2;
  logic [NREQ-1:0] exp_ready;

  task automatic clear_slot(input int k);
    rd_v[k] = 0; rd_a[k] = 0; ov[k] = 0; oid[k] = 0; obase[k] = 0;
    osos[k] = 0; oeos[k] = 0; odat[k] = '0; ev[k] = 0; bv[k] = 0;
  endtask

  always @(negedge clk) if (chk_en) begin
    s = cyc % RING;
    exp_ready = '0;
    win = -1;
    if (!reset && cyc > busy_end) begin
      for (int k = 0; k < NREQ; k++) begin
        if (win < 0 && req_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
      end
      if (win >= 0) exp_ready[win] = 1'b1;
    end
    check("req_ready", req_ready, exp_ready);
    check("mem_rd_en", mem_rd_en, rd_v[s]);
    if (rd_v[s]) check("mem_rd_addr", mem_rd_addr, rd_a[s]);
    check("out_valid", out_valid, ov[s]);
    if (ov[s]) begin
      check("out_id", out_id, oid[s]);
      check("out_data", out_data, odat[s]);
      check("out_fv_base", out_fv_base, obase[s]);
      check("out_sos", out_sos, osos[s]);
      check("out_eos", out_eos, oeos[s]);
    end
    check("err_layer", err_layer, ev[s]);
    check("busy", busy, bv[s]);
    if (mem_rd_en === 1'b1) begin rd_count++; last_rd = cyc; end
    if (err_layer === 1'b1) err_count++;
    clear_slot(s);
    if (reset) begin
      for (int k = 1; k < RING; k++) clear_slot((cyc + k) % RING);
      m_ptr = 0;
      busy_end = cyc;
    end else if (win >= 0) begin
      glog.push_back(win);
      gcyc.push_back(cyc);
      m_ptr = (win + 1) % NREQ;
      lay = int'(req_layer[win]);
      nb = int'(num_fv) / MPE;
      busy_end = cyc;
      if (lay >= MAXL) begin
        ev[(cyc + 1) % RING] = 1;
      end else if (nb > 0) begin
        for (int b = 0; b < nb; b++) begin
          t1 = (cyc + 1 + b) % RING;
          t2 = (cyc + 1 + b + LAT) % RING;
          rd_v[t1] = 1; rd_a[t1] = lay * BPLT + b;
          ov[t2] = 1; oid[t2] = win; obase[t2] = b * MPE;
          osos[t2] = (b == 0); oeos[t2] = (b == nb - 1);
          odat[t2] = mem[lay * BPLT + b];
        end
        for (int k = 1; k <= nb + LAT; k++) bv[(cyc + k) % RING] = 1;
        busy_end = cyc + nb;
      end
    end
  end

  // Requester behaviour: a granted request drops unless marked sticky
  logic [NREQ-1:0] sticky = '0;
  bit rand_nfv = 1'b0;

  task automatic step();
    logic [NREQ-1:0] seen;
    @(negedge clk);
    seen = req_ready;
    @(posedge clk); #1;
    req_valid = req_valid & ~(seen & ~sticky);
    if (rand_nfv) num_fv = 5'($urandom_range(0, 16));
  endtask

  task automatic raise(input int i, input int layer);
    req_layer[i] = 2'(layer);
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((req_valid != '0 || busy !== 1'b0) && n < budget) begin step(); n++; end
    check({tag, "_timeout"}, 64'(n < budget), 64'd1);
    step(); step();
  endtask

  task automatic clear_logs();
    glog.delete(); gcyc.delete(); rd_count = 0; err_count = 0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < MAXL*BPLT; i++) mem[i] = {$urandom, $urandom};
    for (int k = 0; k < RING; k++) clear_slot(k);

    // Reset values, with requests pending to prove ready stays low
    req_valid = 4'b0101;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_mem_rd_addr", mem_rd_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err_layer", err_layer, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    req_valid = '0;
    reset = 1'b0;
    chk_en = 1'b1;
    step();

    // All four requesting, two beats each
    clear_logs();
    num_fv = 5'd8;
    for (int i = 0; i < NREQ; i++) raise(i, i % 2);
    wait_idle("all4", 60);
    check("all4_count", glog.size(), 4);
    for (int k = 0; k < 4; k++) check("all4_order", glog[k], k);
    for (int k = 0; k < 3; k++) check("all4_spacing", gcyc[k+1] - gcyc[k], 3);
    check("all4_span", last_rd - gcyc[0], 11);

    // Single request, full layer
    clear_logs();
    num_fv = 5'd16;
    raise(2, 1);
    wait_idle("single", 30);
    check("single_id", glog[0], 2);
    check("single_beats", rd_count, 4);

    // Fairness: steer pointer to 2, then 1 and 3 request continuously
    num_fv = 5'd4;
    raise(1, 0);
    wait_idle("ptr_setup", 20);
    clear_logs();
    sticky = 4'b1010;
    raise(1, 0);
    raise(3, 1);
    n = 0;
    while (glog.size() < 4 && n < 60) begin step(); n++; end
    sticky = '0;
    wait_idle("rr", 40);
    check("rr_count_ok", 64'(glog.size() >= 4), 1);
    check("rr_g0", glog[0], 3);
    check("rr_g1", glog[1], 1);
    check("rr_g2", glog[2], 3);
    check("rr_g3", glog[3], 1);

    // Single-beat burst
    clear_logs();
    num_fv = 5'd4;
    raise(0, 0);
    wait_idle("one_beat", 20);
    check("one_beat_reads", rd_count, 1);

    // Empty layer: handshake only
    clear_logs();
    num_fv = 5'd0;
    raise(1, 1);
    wait_idle("zero", 20);
    check("zero_grants", glog.size(), 1);
    check("zero_reads", rd_count, 0);
    check("zero_err", err_count, 0);

    // Out-of-range layer
    clear_logs();
    num_fv = 5'd16;
    raise(2, 2);
    wait_idle("badlayer", 20);
    check("badlayer_err", err_count, 1);
    check("badlayer_reads", rd_count, 0);
    check("badlayer_grants", glog.size(), 1);

    // Reset during the second beat of a four-beat burst
    clear_logs();
    num_fv = 5'd16;
    raise(0, 1);
    n = 0;
    while (glog.size() == 0 && n < 20) begin step(); n++; end
    check("abort_grant_seen", glog.size(), 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("abort_rd_en", mem_rd_en, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    clear_logs();
    num_fv = 5'd8;
    for (int i = 0; i < NREQ; i++) raise(NREQ - 1 - i, 1);
    wait_idle("post_reset", 60);
    check("post_reset_first", glog[0], 0);

    // Randomized traffic, including arrivals during bursts
    rand_nfv = 1'b1;
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 1) == 1) raise(i, $urandom_range(0, 3));
      for (int k = 0; k < 10; k++) begin
        int j;
        j = $urandom_range(0, NREQ - 1);
        if (!req_valid[j] && $urandom_range(0, 2) == 0) raise(j, $urandom_range(0, 3));
        step();
      end
      wait_idle("random", 200);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
